// File: rtl/datapath_pkg.sv
// Shared definitions for the CPU datapath and its control unit:
// ALU opcodes, Bus_2 source codes and flag bit positions.
package datapath_pkg;

  localparam int OP_NOP = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_XOR = 5;
  localparam int OP_NOT = 6;
  localparam int OP_SHL = 7;
  localparam int OP_SHR = 8;
  localparam int OP_INC = 9;

  typedef enum logic [1:0] {
    BUS2_ALU  = 2'd0,
    BUS2_BUS1 = 2'd1,
    BUS2_MEM  = 2'd2,
    BUS2_ZERO = 2'd3
  } bus2_sel_e;

  localparam int NUM_FLAGS = 3;
  localparam int FLAG_N    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_Z    = 2;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A is the Y operand register, B is Bus_1.
// Carry is carry-out for ADD/INC, borrow for SUB, shifted-out bit for shifts.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [OP_SIZE-1:0]   opcode,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry
);

  logic [WORD_SIZE:0] sum;
  logic [WORD_SIZE:0] diff;
  logic [WORD_SIZE:0] incr;

  // The extra top bit captures carry-out, or the borrow when a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign incr = {1'b0, b} + (WORD_SIZE+1)'(1);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    result = '0;
    carry  = 1'b0;
    case (int'(opcode))
      OP_NOP: result = '0;
      OP_ADD: {carry, result} = sum;
      OP_SUB: {carry, result} = diff;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~b;
      OP_SHL: begin
        result = b << 1;
        carry  = b[WORD_SIZE-1];
      end
      OP_SHR: begin
        result = b >> 1;
        carry  = b[0];
      end
      OP_INC: {carry, result} = incr;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_unit.sv
// Two-bus CPU datapath: register file, PC, IR, address, Y and flags registers.
// Bus_1 feeds the ALU; Bus_2 is the write-back bus for every register.
module datapath_unit
  import datapath_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int NUM_REGS  = 4,
  parameter int OP_SIZE   = 4,
  parameter int RSEL_W    = $clog2(NUM_REGS),
  parameter int B1SEL_W   = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] mem_word,
  input  logic [B1SEL_W-1:0]   sel_bus_1,
  input  logic [1:0]           sel_bus_2,
  input  logic                 load_reg,
  input  logic [RSEL_W-1:0]    reg_dst,
  input  logic                 load_pc,
  input  logic                 inc_pc,
  input  logic                 load_ir,
  input  logic                 load_add_r,
  input  logic                 load_reg_y,
  input  logic                 load_flags,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [ADDR_SIZE-1:0] address,
  output logic [ADDR_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] bus_1,
  output logic                 zflag,
  output logic                 cflag,
  output logic                 nflag
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [WORD_SIZE-1:0] reg_y;
  logic [WORD_SIZE-1:0] bus_2;
  logic [WORD_SIZE-1:0] alu_result;
  logic                 alu_carry;
  logic [NUM_FLAGS-1:0] flags;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [WORD_SIZE-1:0] q;
    // NOTE: the register file is small flops, not RAM, so resetting it is cheap and expected.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (load_reg && reg_dst == RSEL_W'(i)) begin
        q <= bus_2;
      end
    end
    assign regs[i] = q;
  end

  always_comb begin
    bus_1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_bus_1 == B1SEL_W'(i)) bus_1 = regs[i];
    end
    if (sel_bus_1 == B1SEL_W'(NUM_REGS)) bus_1 = WORD_SIZE'(pc);
  end

  datapath_alu #(
    .WORD_SIZE(WORD_SIZE),
    .OP_SIZE  (OP_SIZE)
  ) u_alu (
    .a     (reg_y),
    .b     (bus_1),
    .opcode(instruction[WORD_SIZE-1 -: OP_SIZE]),
    .result(alu_result),
    .carry (alu_carry)
  );

  always_comb begin
    bus_2 = '0;
    case (bus2_sel_e'(sel_bus_2))
      BUS2_ALU:  bus_2 = alu_result;
      BUS2_BUS1: bus_2 = bus_1;
      BUS2_MEM:  bus_2 = mem_word;
      BUS2_ZERO: bus_2 = '0;
      default:   bus_2 = '0;
    endcase
  end

  // NOTE: non-blocking assignments let every register sample the pre-edge Bus_2 together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instruction <= '0;
      address     <= '0;
      reg_y       <= '0;
      flags       <= '0;
    end else begin
      if (load_pc)     pc <= bus_2[ADDR_SIZE-1:0];
      else if (inc_pc) pc <= pc + ADDR_SIZE'(1);
      if (load_ir)    instruction <= bus_2;
      if (load_add_r) address     <= bus_2[ADDR_SIZE-1:0];
      if (load_reg_y) reg_y       <= bus_2;
      if (load_flags) begin
        flags[FLAG_Z] <= (alu_result == '0);
        flags[FLAG_C] <= alu_carry;
        flags[FLAG_N] <= alu_result[WORD_SIZE-1];
      end
    end
  end

  assign zflag = flags[FLAG_Z];
  assign cflag = flags[FLAG_C];
  assign nflag = flags[FLAG_N];

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench for datapath_unit at NUM_REGS=5: expectations are queued
// with each stimulus step and compared once the DUT outputs have settled.
module tb_datapath_unit;
  import datapath_pkg::*;

  localparam int W  = 8;
  localparam int AW = 8;
  localparam int NR = 5;
  localparam int RS = $clog2(NR);
  localparam int BS = $clog2(NR + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  mem_word;
  logic [BS-1:0] sel_bus_1;
  logic [1:0]    sel_bus_2;
  logic          load_reg;
  logic [RS-1:0] reg_dst;
  logic          load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_flags;
  logic [W-1:0]  instruction;
  logic [AW-1:0] address;
  logic [AW-1:0] pc;
  logic [W-1:0]  bus_1;
  logic          zflag, cflag, nflag;

  datapath_unit #(
    .WORD_SIZE(W), .ADDR_SIZE(AW), .NUM_REGS(NR), .OP_SIZE(4)
  ) dut (
    .clk(clk), .rst(rst), .mem_word(mem_word),
    .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2),
    .load_reg(load_reg), .reg_dst(reg_dst),
    .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
    .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_flags(load_flags),
    .instruction(instruction), .address(address), .pc(pc), .bus_1(bus_1),
    .zflag(zflag), .cflag(cflag), .nflag(nflag)
  );

  always #5 clk = ~clk;

  typedef enum {S_BUS1, S_PC, S_IR, S_ADDR, S_Z, S_C, S_N} sig_e;
  typedef struct {
    string        tag;
    sig_e         sig;
    logic [W-1:0] exp;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, c, n;
  } op_vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] observe(input sig_e s);
    case (s)
      S_BUS1:  return bus_1;
      S_PC:    return W'(pc);
      S_IR:    return instruction;
      S_ADDR:  return W'(address);
      S_Z:     return W'(zflag);
      S_C:     return W'(cflag);
      default: return W'(nflag);
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic peek();
    #1;
    drain();
  endtask

  task automatic idle();
    rst = 1'b0; mem_word = '0; sel_bus_1 = '0; sel_bus_2 = 2'd3;
    load_reg = 1'b0; reg_dst = '0; load_pc = 1'b0; inc_pc = 1'b0;
    load_ir = 1'b0; load_add_r = 1'b0; load_reg_y = 1'b0; load_flags = 1'b0;
  endtask

  task automatic expect_regs(input string tag, input logic [W-1:0] v [NR]);
    for (int i = 0; i < NR; i++) begin
      sel_bus_1 = BS'(i);
      expect_val($sformatf("%s_r%0d", tag, i), S_BUS1, v[i]);
      peek();
    end
  endtask

  task automatic mem_to_reg(input logic [W-1:0] v, input int dst);
    idle(); mem_word = v; sel_bus_2 = 2'd2; load_reg = 1'b1; reg_dst = RS'(dst);
    tick();
  endtask

  task automatic run_op(input op_vec_t t);
    idle(); mem_word = t.a; sel_bus_2 = 2'd2; load_reg_y = 1'b1; tick();
    mem_to_reg(t.b, 3);
    idle(); mem_word = {t.op, 4'h0}; sel_bus_2 = 2'd2; load_ir = 1'b1;
    expect_val($sformatf("op%0d_ir", t.op), S_IR, {t.op, 4'h0});
    tick();
    idle(); sel_bus_1 = 3'd3; sel_bus_2 = 2'd0; load_reg = 1'b1; reg_dst = 3'd4; load_flags = 1'b1;
    expect_val($sformatf("op%0d_z", t.op), S_Z, W'(t.z));
    expect_val($sformatf("op%0d_c", t.op), S_C, W'(t.c));
    expect_val($sformatf("op%0d_n", t.op), S_N, W'(t.n));
    tick();
    idle(); sel_bus_1 = 3'd4;
    expect_val($sformatf("op%0d_res", t.op), S_BUS1, t.res);
    peek();
  endtask

  op_vec_t      vecs [14];
  logic [W-1:0] exp_regs [NR];

  initial begin
    vecs[0]  = '{op:4'd1,  a:8'hFF, b:8'h01, res:8'h00, z:1, c:1, n:0};
    vecs[1]  = '{op:4'd2,  a:8'h03, b:8'h05, res:8'hFE, z:0, c:1, n:1};
    vecs[2]  = '{op:4'd8,  a:8'h00, b:8'h01, res:8'h00, z:1, c:1, n:0};
    vecs[3]  = '{op:4'd3,  a:8'hF0, b:8'h3C, res:8'h30, z:0, c:0, n:0};
    vecs[4]  = '{op:4'd4,  a:8'hF0, b:8'h0F, res:8'hFF, z:0, c:0, n:1};
    vecs[5]  = '{op:4'd5,  a:8'hAA, b:8'hFF, res:8'h55, z:0, c:0, n:0};
    vecs[6]  = '{op:4'd6,  a:8'h00, b:8'h0F, res:8'hF0, z:0, c:0, n:1};
    vecs[7]  = '{op:4'd7,  a:8'h00, b:8'h81, res:8'h02, z:0, c:1, n:0};
    vecs[8]  = '{op:4'd9,  a:8'h00, b:8'hFF, res:8'h00, z:1, c:1, n:0};
    vecs[9]  = '{op:4'd10, a:8'h12, b:8'h34, res:8'h00, z:1, c:0, n:0};
    vecs[10] = '{op:4'd0,  a:8'h12, b:8'h34, res:8'h00, z:1, c:0, n:0};
    vecs[11] = '{op:4'd2,  a:8'h05, b:8'h05, res:8'h00, z:1, c:0, n:0};
    vecs[12] = '{op:4'd1,  a:8'h40, b:8'h40, res:8'h80, z:0, c:0, n:1};
    vecs[13] = '{op:4'd8,  a:8'h00, b:8'h80, res:8'h40, z:0, c:0, n:0};

    // Reset with every strobe asserted: reset must win.
    rst = 1'b1; mem_word = 8'hA5; sel_bus_1 = '0; sel_bus_2 = 2'd2;
    load_reg = 1'b1; reg_dst = '0; load_pc = 1'b1; inc_pc = 1'b1;
    load_ir = 1'b1; load_add_r = 1'b1; load_reg_y = 1'b1; load_flags = 1'b1;
    expect_val("rst_pc", S_PC, 8'h00);
    expect_val("rst_ir", S_IR, 8'h00);
    expect_val("rst_addr", S_ADDR, 8'h00);
    expect_val("rst_z", S_Z, 8'h00);
    expect_val("rst_c", S_C, 8'h00);
    expect_val("rst_n", S_N, 8'h00);
    tick();
    idle();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    expect_regs("rst", exp_regs);
    sel_bus_1 = 3'd5;
    expect_val("rst_bus1_pc", S_BUS1, 8'h00);
    peek();

    // Y cleared by reset: ADD with Bus_1 = 0 (select 6) returns Y.
    idle(); mem_word = 8'h10; sel_bus_2 = 2'd2; load_ir = 1'b1; tick();
    idle(); sel_bus_1 = 3'd6; sel_bus_2 = 2'd0; load_reg = 1'b1; reg_dst = 3'd0; tick();
    idle(); sel_bus_1 = 3'd0;
    expect_val("y_reset", S_BUS1, 8'h00);
    peek();

    // Memory word into R2; the others stay zero.
    mem_to_reg(8'h7F, 2);
    idle();
    exp_regs[2] = 8'h7F;
    expect_regs("ld_r2", exp_regs);

    // Bus_2 zero select clears R2.
    idle(); sel_bus_2 = 2'd3; load_reg = 1'b1; reg_dst = 3'd2; tick();
    idle(); sel_bus_1 = 3'd2;
    expect_val("r2_zero", S_BUS1, 8'h00);
    peek();

    // R1 <- R1 via Bus_1 with load_reg_y: both get old R1, then Y+R1 = 0x22.
    mem_to_reg(8'h11, 1);
    idle(); sel_bus_1 = 3'd1; sel_bus_2 = 2'd1; load_reg = 1'b1; reg_dst = 3'd1; load_reg_y = 1'b1; tick();
    idle(); mem_word = 8'h10; sel_bus_2 = 2'd2; load_ir = 1'b1; tick();
    idle(); sel_bus_1 = 3'd1; sel_bus_2 = 2'd0; load_reg = 1'b1; reg_dst = 3'd0; tick();
    idle(); sel_bus_1 = 3'd0;
    expect_val("simul_y_r1", S_BUS1, 8'h22);
    peek();

    foreach (vecs[k]) run_op(vecs[k]);

    // PC wrap, load-over-increment priority, PC on Bus_1.
    idle(); mem_word = 8'hFF; sel_bus_2 = 2'd2; load_pc = 1'b1;
    expect_val("pc_load_ff", S_PC, 8'hFF);
    tick();
    idle(); inc_pc = 1'b1;
    expect_val("pc_wrap", S_PC, 8'h00);
    tick();
    idle(); mem_word = 8'h40; sel_bus_2 = 2'd2; load_pc = 1'b1; inc_pc = 1'b1;
    expect_val("pc_load_prio", S_PC, 8'h40);
    tick();
    idle(); sel_bus_1 = 3'd5;
    expect_val("bus1_pc", S_BUS1, 8'h40);
    peek();
    sel_bus_1 = 3'd6;
    expect_val("bus1_sel6", S_BUS1, 8'h00);
    peek();
    sel_bus_1 = 3'd7;
    expect_val("bus1_sel7", S_BUS1, 8'h00);
    peek();
    idle(); mem_word = 8'h3C; sel_bus_2 = 2'd2; load_add_r = 1'b1;
    expect_val("addr_load", S_ADDR, 8'h3C);
    tick();
    idle(); rst = 1'b1; inc_pc = 1'b1;
    expect_val("rst_pc_inc", S_PC, 8'h00);
    expect_val("rst_addr2", S_ADDR, 8'h00);
    expect_val("rst_z2", S_Z, 8'h00);
    tick();

    // Out-of-range destinations write nothing.
    for (int d = NR; d < 8; d++) mem_to_reg(8'h99, d);
    idle();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    expect_regs("bad_dst", exp_regs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
